// File: rtl/pacman_pkg.sv
// Shared Pac-Man sprite types: travel direction, motion FSM state codes, sprite size and
// direction helpers used by the motion controller, pacman_sprite and the ghost controllers.
package pacman_pkg;

  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PROBE_DES = 3'd1;
  localparam state_t ST_WAIT_DES  = 3'd2;
  localparam state_t ST_PROBE_CUR = 3'd3;
  localparam state_t ST_WAIT_CUR  = 3'd4;
  localparam state_t ST_MOVE      = 3'd5;
  localparam state_t ST_STALL     = 3'd6;

  localparam int SPRITE_W = 8;
  localparam int SPRITE_H = 8;

  // Renderer orientation code {h_flip, v_flip} for a facing direction.
  function automatic logic [1:0] dir_flips(input dir_t d);
    case (d)
      DIR_RIGHT: return 2'b11;
      DIR_LEFT:  return 2'b01;
      DIR_UP:    return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic dir_is_horiz(input dir_t d);
    return (d == DIR_RIGHT) || (d == DIR_LEFT);
  endfunction

endpackage

// File: rtl/pacman_motion_ctrl_if.sv
// Wall-map lookup port: the motion controller is master, the tile-map wall lookup is slave.
interface pacman_motion_ctrl_if;
  logic       wall_req;
  logic [8:0] wall_x;
  logic [8:0] wall_y;
  logic       wall_ack;
  logic       wall_hit;

  modport master (output wall_req, wall_x, wall_y, input wall_ack, wall_hit);
  modport slave  (input wall_req, wall_x, wall_y, output wall_ack, wall_hit);
endinterface

// File: rtl/pacman_probe_addr.sv
// Combinational probe point for a sprite at (i_x, i_y) stepping STEP pixels in i_dir:
// the pixel just past the leading edge, plus whether it lies inside the playfield.
module pacman_probe_addr
  import pacman_pkg::*;
#(
  parameter int X_MAX = 216,
  parameter int Y_MAX = 280,
  parameter int STEP  = 1
) (
  input  logic [8:0] i_x,
  input  logic [8:0] i_y,
  input  dir_t       i_dir,
  output logic [8:0] o_probe_x,
  output logic [8:0] o_probe_y,
  output logic       o_in_range
);

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] FAR_X  = 11'(SPRITE_W - 1);
  localparam logic signed [10:0] FAR_Y  = 11'(SPRITE_H - 1);
  localparam logic signed [10:0] MID_X  = 11'(SPRITE_W / 2 - 1);
  localparam logic signed [10:0] MID_Y  = 11'(SPRITE_H / 2 - 1);
  localparam logic signed [10:0] X_LIM  = 11'(X_MAX + SPRITE_W - 1);
  localparam logic signed [10:0] Y_LIM  = 11'(Y_MAX + SPRITE_H - 1);

  logic signed [10:0] w_x;
  logic signed [10:0] w_y;
  logic signed [10:0] w_px;
  logic signed [10:0] w_py;

  assign w_x = signed'({2'b00, i_x});
  assign w_y = signed'({2'b00, i_y});

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    w_px = w_x;
    w_py = w_y;
    case (i_dir)
      DIR_RIGHT: begin w_px = w_x + FAR_X + STEP_S; w_py = w_y + MID_Y;          end
      DIR_LEFT:  begin w_px = w_x - STEP_S;         w_py = w_y + MID_Y;          end
      DIR_DOWN:  begin w_px = w_x + MID_X;          w_py = w_y + FAR_Y + STEP_S; end
      DIR_UP:    begin w_px = w_x + MID_X;          w_py = w_y - STEP_S;         end
      default:   ;
    endcase
  end

  assign o_in_range = (w_px >= 11'sd0) && (w_px <= X_LIM) &&
                      (w_py >= 11'sd0) && (w_py <= Y_LIM);
  assign o_probe_x  = w_px[8:0];
  assign o_probe_y  = w_py[8:0];

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Per-frame Pac-Man movement sequencer: samples the joystick, probes the wall map for the
// desired then the current direction, and steps the sprite. Option macro: PACMAN_TUNNEL_WRAP_EN.
module pacman_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int X_MAX    = 216,
  parameter int Y_MAX    = 280,
  parameter int START_X  = 108,
  parameter int START_Y  = 212,
  parameter int STEP     = 1,
  parameter int MOVE_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [3:0]           dir_in,
  pacman_motion_ctrl_if.master wall,
  output logic [8:0]           x_pac,
  output logic [8:0]           y_pac,
  output logic                 h_flip,
  output logic                 v_flip,
  output logic                 moving,
  output logic                 busy
);

`ifdef PACMAN_TUNNEL_WRAP_EN
  localparam logic TUNNEL_WRAP = 1'b1;
`else
  localparam logic TUNNEL_WRAP = 1'b0;
`endif

  localparam logic [3:0]         DIV_LAST = 4'(MOVE_DIV - 1);
  localparam logic [8:0]         X_MAX_9  = 9'(X_MAX);
  localparam logic [8:0]         Y_MAX_9  = 9'(Y_MAX);
  localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);

  state_t     r_state;
  dir_t       r_cur_dir;
  dir_t       r_des_dir;
  logic [3:0] r_div;
  logic [8:0] r_x;
  logic [8:0] r_y;
  logic       r_h_flip;
  logic       r_v_flip;
  logic       r_moving;
  logic       r_wall_req;
  logic [8:0] r_wall_x;
  logic [8:0] r_wall_y;

  logic               w_dir_valid;
  dir_t               w_dir_sample;
  logic [8:0]         w_des_px, w_des_py, w_cur_px, w_cur_py;
  logic               w_des_in_range, w_cur_in_range;
  logic               w_des_oor_open, w_cur_oor_open;
  logic signed [10:0] w_mx, w_my;
  logic [8:0]         w_next_x, w_next_y;

  pacman_probe_addr #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP)) u_probe_des (
    .i_x(r_x), .i_y(r_y), .i_dir(r_des_dir),
    .o_probe_x(w_des_px), .o_probe_y(w_des_py), .o_in_range(w_des_in_range)
  );

  pacman_probe_addr #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP)) u_probe_cur (
    .i_x(r_x), .i_y(r_y), .i_dir(r_cur_dir),
    .o_probe_x(w_cur_px), .o_probe_y(w_cur_py), .o_in_range(w_cur_in_range)
  );

  // Only a single asserted joystick line names a direction; anything else keeps the old wish.
  always_comb begin
    w_dir_valid  = 1'b1;
    w_dir_sample = DIR_LEFT;
    case (dir_in)
      4'b0001: w_dir_sample = DIR_RIGHT;
      4'b0010: w_dir_sample = DIR_LEFT;
      4'b0100: w_dir_sample = DIR_DOWN;
      4'b1000: w_dir_sample = DIR_UP;
      default: w_dir_valid  = 1'b0;
    endcase
  end

  // Off-playfield probes are only passable sideways, and only through the tunnel.
  assign w_des_oor_open = TUNNEL_WRAP && dir_is_horiz(r_des_dir);
  assign w_cur_oor_open = TUNNEL_WRAP && dir_is_horiz(r_cur_dir);

  always_comb begin
    w_mx = signed'({2'b00, r_x});
    w_my = signed'({2'b00, r_y});
    case (r_cur_dir)
      DIR_RIGHT: w_mx = w_mx + STEP_S;
      DIR_LEFT:  w_mx = w_mx - STEP_S;
      DIR_DOWN:  w_my = w_my + STEP_S;
      DIR_UP:    w_my = w_my - STEP_S;
      default:   ;
    endcase

    if (w_mx < 11'sd0)        w_next_x = TUNNEL_WRAP ? X_MAX_9 : 9'd0;
    else if (w_mx > X_MAX_S)  w_next_x = TUNNEL_WRAP ? 9'd0 : X_MAX_9;
    else                      w_next_x = w_mx[8:0];

    if (w_my < 11'sd0)        w_next_y = 9'd0;
    else if (w_my > Y_MAX_S)  w_next_y = Y_MAX_9;
    else                      w_next_y = w_my[8:0];
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cur_dir  <= DIR_LEFT;
      r_des_dir  <= DIR_LEFT;
      r_div      <= '0;
      r_x        <= 9'(START_X);
      r_y        <= 9'(START_Y);
      r_h_flip   <= 1'b0;
      r_v_flip   <= 1'b1;
      r_moving   <= 1'b0;
      r_wall_req <= 1'b0;
      r_wall_x   <= '0;
      r_wall_y   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (frame_tick) begin
            if (w_dir_valid) r_des_dir <= w_dir_sample;
            if (r_div == DIV_LAST) begin
              r_div   <= '0;
              r_state <= ST_PROBE_DES;
            end else begin
              r_div   <= r_div + 4'd1;
            end
          end
        end

        ST_PROBE_DES: begin
          if (w_des_in_range) begin
            r_wall_req <= 1'b1;
            r_wall_x   <= w_des_px;
            r_wall_y   <= w_des_py;
            r_state    <= ST_WAIT_DES;
          end else if (w_des_oor_open) begin
            r_cur_dir              <= r_des_dir;
            {r_h_flip, r_v_flip}   <= dir_flips(r_des_dir);
            r_state                <= ST_MOVE;
          end else begin
            r_state <= (r_des_dir == r_cur_dir) ? ST_STALL : ST_PROBE_CUR;
          end
        end

        ST_WAIT_DES: begin
          if (wall.wall_ack) begin
            r_wall_req <= 1'b0;
            if (!wall.wall_hit) begin
              r_cur_dir            <= r_des_dir;
              {r_h_flip, r_v_flip} <= dir_flips(r_des_dir);
              r_state              <= ST_MOVE;
            end else begin
              r_state <= (r_des_dir == r_cur_dir) ? ST_STALL : ST_PROBE_CUR;
            end
          end
        end

        ST_PROBE_CUR: begin
          if (w_cur_in_range) begin
            r_wall_req <= 1'b1;
            r_wall_x   <= w_cur_px;
            r_wall_y   <= w_cur_py;
            r_state    <= ST_WAIT_CUR;
          end else begin
            r_state <= w_cur_oor_open ? ST_MOVE : ST_STALL;
          end
        end

        ST_WAIT_CUR: begin
          if (wall.wall_ack) begin
            r_wall_req <= 1'b0;
            r_state    <= wall.wall_hit ? ST_STALL : ST_MOVE;
          end
        end

        ST_MOVE: begin
          r_x      <= w_next_x;
          r_y      <= w_next_y;
          r_moving <= 1'b1;
          r_state  <= ST_IDLE;
        end

        ST_STALL: begin
          r_moving <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wall.wall_req = r_wall_req;
  assign wall.wall_x   = r_wall_x;
  assign wall.wall_y   = r_wall_y;
  assign x_pac         = r_x;
  assign y_pac         = r_y;
  assign h_flip        = r_h_flip;
  assign v_flip        = r_v_flip;
  assign moving        = r_moving;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Bench for pacman_motion_ctrl: directed scenarios, boundary walks and random moves against a
// per-move-event reference model and a bench-owned wall map. Honours PACMAN_TUNNEL_WRAP_EN.
module tb_pacman_motion_ctrl;

  localparam int X_MAX   = 216;
  localparam int Y_MAX   = 280;
  localparam int START_X = 108;
  localparam int START_Y = 212;
  localparam int STEP    = 1;
  localparam int PW      = X_MAX + 8;
  localparam int PH      = Y_MAX + 8;
  localparam int MR = 0, ML = 1, MU = 2, MD = 3;

`ifdef PACMAN_TUNNEL_WRAP_EN
  localparam bit TUNNEL = 1'b1;
`else
  localparam bit TUNNEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] dir_in = 4'd0;
  logic [8:0] x_pac, y_pac;
  logic       h_flip, v_flip, moving, busy;

  pacman_motion_ctrl_if wall_bus();

  pacman_motion_ctrl #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .START_X(START_X), .START_Y(START_Y),
    .STEP(STEP), .MOVE_DIV(1)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .dir_in(dir_in), .wall(wall_bus),
    .x_pac(x_pac), .y_pac(y_pac), .h_flip(h_flip), .v_flip(v_flip),
    .moving(moving), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit wmap [PH][PW];
  int m_x, m_y, m_cur, m_des;
  bit m_moving;
  int exp_req_x[$];
  int exp_req_y[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_cur = ML; m_des = ML; m_moving = 1'b0;
  endtask

  task automatic probe_pt(input int d, output int px, output int py);
    case (d)
      MR:      begin px = m_x + 7 + STEP; py = m_y + 3;        end
      ML:      begin px = m_x - STEP;     py = m_y + 3;        end
      MD:      begin px = m_x + 3;        py = m_y + 7 + STEP; end
      default: begin px = m_x + 3;        py = m_y - STEP;     end
    endcase
  endtask

  // A probe is open if it lands on a free map pixel; off the playfield only the tunnel passes.
  task automatic model_probe(input int d, output bit is_open);
    int px, py;
    probe_pt(d, px, py);
    if (px >= 0 && px < PW && py >= 0 && py < PH) begin
      exp_req_x.push_back(px);
      exp_req_y.push_back(py);
      is_open = !wmap[py][px];
    end else begin
      is_open = TUNNEL && (d == MR || d == ML);
    end
  endtask

  task automatic model_move();
    case (m_cur)
      MR: begin m_x = m_x + STEP; if (m_x > X_MAX) m_x = 0;     end
      ML: begin m_x = m_x - STEP; if (m_x < 0)     m_x = X_MAX; end
      MU: m_y = m_y - STEP;
      default: m_y = m_y + STEP;
    endcase
    m_moving = 1'b1;
  endtask

  task automatic model_event(input logic [3:0] d);
    bit ok;
    case (d)
      4'b0001: m_des = MR;
      4'b0010: m_des = ML;
      4'b0100: m_des = MD;
      4'b1000: m_des = MU;
      default: ;
    endcase
    model_probe(m_des, ok);
    if (ok) begin
      m_cur = m_des;
      model_move();
    end else if (m_des == m_cur) begin
      m_moving = 1'b0;
    end else begin
      model_probe(m_cur, ok);
      if (ok) model_move();
      else    m_moving = 1'b0;
    end
  endtask

  function automatic int exp_h(input int d);
    return (d == MR || d == MU) ? 1 : 0;
  endfunction

  function automatic int exp_v(input int d);
    return (d == MR || d == ML) ? 1 : 0;
  endfunction

  task automatic clear_map();
    for (int y = 0; y < PH; y++)
      for (int x = 0; x < PW; x++)
        wmap[y][x] = 1'b0;
  endtask

  task automatic wall_at_probe(input int d);
    int px, py;
    probe_pt(d, px, py);
    if (px >= 0 && px < PW && py >= 0 && py < PH) wmap[py][px] = 1'b1;
  endtask

  // One frame tick plus the wall-lookup responder; fixed_lat < 0 picks a random ack latency.
  task automatic run_event(input logic [3:0] d, input int fixed_lat);
    int  cycles = 0, nreq = 0, since_ack = 0, exp_n, lat, hx, hy;
    bit  timed_out = 1'b0;
    exp_req_x.delete();
    exp_req_y.delete();
    model_event(d);
    exp_n = exp_req_x.size();
    @(negedge clk);
    frame_tick = 1'b1;
    dir_in     = d;
    @(negedge clk);
    frame_tick = 1'b0;
    dir_in     = 4'($urandom);
    forever begin
      frame_tick = 1'b0;
      if (!busy) break;
      if (cycles > 60) begin timed_out = 1'b1; break; end
      if (wall_bus.wall_req) begin
        hx = int'(wall_bus.wall_x);
        hy = int'(wall_bus.wall_y);
        if (nreq < exp_n) begin
          check("req_x", hx, exp_req_x[nreq]);
          check("req_y", hy, exp_req_y[nreq]);
        end
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        repeat (lat) begin @(negedge clk); cycles++; end
        check("req_hold", int'(wall_bus.wall_req), 1);
        check("req_x_stable", int'(wall_bus.wall_x), hx);
        check("req_y_stable", int'(wall_bus.wall_y), hy);
        wall_bus.wall_ack = 1'b1;
        wall_bus.wall_hit = (hx < PW && hy < PH) ? wmap[hy][hx] : 1'b1;
        @(negedge clk);
        wall_bus.wall_ack = 1'b0;
        wall_bus.wall_hit = 1'b0;
        check("req_drop", int'(wall_bus.wall_req), 0);
        nreq++;
        cycles++;
        since_ack = 0;
        continue;
      end
      // Ticks landing while busy must be dropped together with their joystick sample.
      frame_tick = ($urandom_range(0, 3) == 0);
      dir_in     = 4'($urandom);
      @(negedge clk);
      cycles++;
      since_ack++;
    end
    frame_tick = 1'b0;
    check("timeout", int'(timed_out), 0);
    check("req_count", nreq, exp_n);
    if (nreq > 0) check("settle_le8", int'(since_ack <= 8), 1);
    check("x_pac", int'(x_pac), m_x);
    check("y_pac", int'(y_pac), m_y);
    check("h_flip", int'(h_flip), exp_h(m_cur));
    check("v_flip", int'(v_flip), exp_v(m_cur));
    check("moving", int'(moving), int'(m_moving));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"}, int'(x_pac), START_X);
    check({tag, "_y"}, int'(y_pac), START_Y);
    check({tag, "_h"}, int'(h_flip), 0);
    check({tag, "_v"}, int'(v_flip), 1);
    check({tag, "_req"}, int'(wall_bus.wall_req), 0);
    check({tag, "_wx"}, int'(wall_bus.wall_x), 0);
    check({tag, "_wy"}, int'(wall_bus.wall_y), 0);
    check({tag, "_moving"}, int'(moving), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int   n;
    logic [3:0] d;
    wall_bus.wall_ack = 1'b0;
    wall_bus.wall_hit = 1'b0;
    clear_map();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b1;

    // Right into open floor, ack two cycles after the request.
    run_event(4'b0001, 2);
    check("t1_x", int'(x_pac), START_X + 1);

    // Desired UP is blocked, current RIGHT is open.
    wall_at_probe(MU);
    run_event(4'b1000, 1);
    check("t2_x", int'(x_pac), START_X + 2);
    clear_map();

    // Both probes blocked: stall in place.
    wall_at_probe(MD);
    wall_at_probe(MR);
    run_event(4'b0100, 0);
    check("t3_moving", int'(moving), 0);
    clear_map();

    // Edge walks over an open map, covering the tunnel and the clamps.
    for (int i = 0; i < 112; i++) run_event(4'b0010, -1);
    for (int i = 0; i < 215; i++) run_event(4'b1000, -1);
    for (int i = 0; i < 230; i++) run_event(4'b0001, -1);
    for (int i = 0; i < 290; i++) run_event(4'b0100, -1);

    // Random joystick over a random maze, including idle and multi-hot inputs.
    for (int y = 0; y < PH; y++)
      for (int x = 0; x < PW; x++)
        wmap[y][x] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 5));
      case (n)
        0: d = 4'b0001;
        1: d = 4'b0010;
        2: d = 4'b0100;
        3: d = 4'b1000;
        4: d = 4'b0000;
        default: d = 4'($urandom);
      endcase
      run_event(d, -1);
    end

    // Reset in the middle of a lookup, then a stale ack after release.
    clear_map();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    frame_tick = 1'b1;
    dir_in     = 4'b0001;
    @(negedge clk);
    frame_tick = 1'b0;
    n = 0;
    while (!wall_bus.wall_req && n < 10) begin @(negedge clk); n++; end
    check("rstmid_req_seen", int'(wall_bus.wall_req), 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("rstmid");
    @(negedge clk);
    rst = 1'b1;
    wall_bus.wall_ack = 1'b1;
    wall_bus.wall_hit = 1'b0;
    @(negedge clk);
    wall_bus.wall_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("lateack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
